// File: rtl/and_run_monitor_pkg.sv
// Shared definitions for the AND-unit run monitor:
// FSM state encodings and default widths.
package and_run_monitor_pkg;

    // Width of the AND unit output word.
    localparam int AND_NBITS = 1;
    // Run-length counter width.
    localparam int AND_CNT_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/and_run_monitor_sat_counter.sv
// sat_counter: CNT_W-bit saturating counter with clear, load-1, increment.
// Ports: clk, rst_n, clr, load1, inc -> cnt, sat (count is at its maximum).
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load1,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        unique case (1'b1)
            clr:     cnt_nxt = '0;
            load1:   cnt_nxt = ONE;
            inc:     cnt_nxt = (cnt == MAX) ? MAX : cnt + ONE;
            default: cnt_nxt = cnt;
        endcase
    end

    // sat tracks the registered count so it can travel with cnt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sat <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            sat <= (cnt_nxt == MAX);
        end
    end

endmodule

// File: rtl/and_run_monitor.sv
// and_run_monitor: measures runs of all-ones and_out words, reports lengths on a 1-deep valid/ready slot.
// Ports: clk, rst_n, in_data, clr, out_ready -> out_valid, out_len, out_sat, ovf (+out_ts with AND_RUN_TIMESTAMP_EN).
module and_run_monitor
    import and_run_monitor_pkg::*;
#(
    parameter int NBITS = AND_NBITS,
    parameter int CNT_W = AND_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NBITS-1:0] in_data,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_len,
    output logic             out_sat,
`ifdef AND_RUN_TIMESTAMP_EN
    output logic             ovf,
    output logic [CNT_W-1:0] out_ts
`else
    output logic             ovf
`endif
);

    state_t state;
    state_t state_nxt;

    logic             hit;
    logic             run_start;
    logic             run_inc;
    logic             run_end;
    logic [CNT_W-1:0] cnt;
    logic             sat;
    logic             slot_free;
    logic             load;
    logic             drop;

    assign hit = &in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (hit)  state_nxt = ST_RUN;
            ST_RUN:  if (!hit) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        run_start = 1'b0;
        run_inc   = 1'b0;
        run_end   = 1'b0;
        unique case (state)
            ST_IDLE: run_start = hit;
            ST_RUN: begin
                run_inc = hit;
                run_end = !hit;
            end
            default: ;
        endcase
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (run_end),
        .load1(run_start),
        .inc  (run_inc),
        .cnt  (cnt),
        .sat  (sat)
    );

    // An accept in the same cycle frees the slot for the new report.
    assign slot_free = !out_valid || out_ready;
    assign load      = run_end && slot_free;
    assign drop      = run_end && !slot_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_len   <= '0;
            out_sat   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_len   <= cnt;
            out_sat   <= sat;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // A drop beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (clr) begin
            ovf <= 1'b0;
        end
    end

`ifdef AND_RUN_TIMESTAMP_EN
    logic [CNT_W-1:0] ts_cnt;
    logic [CNT_W-1:0] run_ts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt <= '0;
            run_ts <= '0;
            out_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + CNT_W'(1);
            if (run_start) begin
                run_ts <= ts_cnt;
            end
            if (load) begin
                out_ts <= run_ts;
            end
        end
    end
`endif

endmodule

// File: tb/tb_and_run_monitor.sv
// Testbench for and_run_monitor: two widths driven in parallel,
// checked each cycle against a run-length model plus directed literals.
module tb_and_run_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] in_data;
    logic       clr;
    logic       out_ready;

    logic       v0, s0, o0;
    logic [7:0] l0;
    logic       v1, s1, o1;
    logic [2:0] l1;
`ifdef AND_RUN_TIMESTAMP_EN
    logic [7:0] t0;
    logic [2:0] t1;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int acc0   = 0;

    always #5 clk = ~clk;

    and_run_monitor #(.NBITS(2), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .clr(clr),
        .out_valid(v0), .out_ready(out_ready), .out_len(l0),
        .out_sat(s0),
`ifdef AND_RUN_TIMESTAMP_EN
        .ovf(o0), .out_ts(t0)
`else
        .ovf(o0)
`endif
    );

    and_run_monitor #(.NBITS(2), .CNT_W(3)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .clr(clr),
        .out_valid(v1), .out_ready(out_ready), .out_len(l1),
        .out_sat(s1),
`ifdef AND_RUN_TIMESTAMP_EN
        .ovf(o1), .out_ts(t1)
`else
        .ovf(o1)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Model: unbounded run length; a report is min(len, max) with
    // sat when the true length reached max; one-entry slot.
    int  run;
    int  ccnt;
    int  start_ts;
    bit  mv[2];
    int  ml[2];
    bit  ms[2];
    bit  mo[2];
    int  mts[2];
    bit  h;
    bit  ended;
    int  mx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run = 0;
            ccnt = 0;
            start_ts = 0;
            for (int i = 0; i < 2; i++) begin
                mv[i] = 0; ml[i] = 0; ms[i] = 0; mo[i] = 0; mts[i] = 0;
            end
        end else begin
            h = &in_data;
            ended = (run > 0) && !h;
            for (int i = 0; i < 2; i++) begin
                mx = (i == 0) ? 255 : 7;
                if (ended && mv[i] && !out_ready) begin
                    mo[i] = 1;
                end else begin
                    if (clr) mo[i] = 0;
                    if (ended) begin
                        mv[i] = 1;
                        ml[i] = (run < mx) ? run : mx;
                        ms[i] = (run >= mx);
                        mts[i] = start_ts % (mx + 1);
                    end else if (mv[i] && out_ready) begin
                        mv[i] = 0;
                    end
                end
            end
            if (h && run == 0) start_ts = ccnt;
            run = h ? run + 1 : 0;
            ccnt++;
        end
    end

    always @(posedge clk) begin
        if (rst_n && v0 && out_ready) acc0++;
    end

    always @(negedge clk) begin
        chk("valid0", v0, mv[0]);
        chk("ovf0", o0, mo[0]);
        chk("valid1", v1, mv[1]);
        chk("ovf1", o1, mo[1]);
        if (mv[0]) begin
            chk("len0", l0, ml[0]);
            chk("sat0", s0, ms[0]);
`ifdef AND_RUN_TIMESTAMP_EN
            chk("ts0", t0, mts[0]);
`endif
        end
        if (mv[1]) begin
            chk("len1", l1, ml[1]);
            chk("sat1", s1, ms[1]);
`ifdef AND_RUN_TIMESTAMP_EN
            chk("ts1", t1, mts[1]);
`endif
        end
    end

    // Inputs change just after a negedge; returns after the next negedge.
    task automatic cyc(input logic [1:0] d, input logic r, input logic c);
        in_data = d;
        out_ready = r;
        clr = c;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    int acc_base;

    initial begin
        rst_n = 1'b0;
        in_data = 2'b11;
        out_ready = 1'b1;
        clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", v0, 0);
        chk("rst_len", l0, 0);
        chk("rst_ovf", o0, 0);
        rst_n = 1'b1;

        // run of 2 right after reset; partial 0b01 word is not a hit
        cyc(2'b11, 1, 0);
        chk("no_early_rpt", v0, 0);
        cyc(2'b11, 1, 0);
        cyc(2'b01, 1, 0);
        chk("first_valid", v0, 1);
        chk("first_len", l0, 2);

        // run of 5, report lasts one cycle
        repeat (5) cyc(2'b11, 1, 0);
        cyc(2'b00, 1, 0);
        chk("r5_valid", v0, 1);
        chk("r5_len", l0, 5);
        chk("r5_sat", s0, 0);
        chk("r5_len_w3", l1, 5);
        chk("m_r5_len", ml[0], 5);
        cyc(2'b00, 1, 0);
        chk("r5_one_cycle", v0, 0);

        // run of 10: saturates only the 3-bit instance
        repeat (10) cyc(2'b11, 1, 0);
        cyc(2'b10, 1, 0);
        chk("r10_len", l0, 10);
        chk("r10_sat", s0, 0);
        chk("r10_len_w3", l1, 7);
        chk("r10_sat_w3", s1, 1);
        chk("m_r10_sat_w3", ms[1], 1);
        cyc(2'b00, 1, 0);

        // stalled consumer: 2-run held, 3-run dropped
        repeat (2) cyc(2'b11, 0, 0);
        cyc(2'b00, 0, 0);
        chk("hold_len", l0, 2);
        repeat (3) cyc(2'b11, 0, 0);
        cyc(2'b00, 0, 0);
        chk("drop_len", l0, 2);
        chk("drop_ovf", o0, 1);
        chk("drop_ovf_w3", o1, 1);
        cyc(2'b00, 0, 1);
        chk("clr_ovf", o0, 0);
        cyc(2'b00, 1, 0);
        chk("drain_valid", v0, 0);

        // 1,0,1,0,1 with an accept coinciding with a run end
        acc_base = acc0;
        cyc(2'b11, 1, 0);
        cyc(2'b00, 1, 0);
        chk("b2b_v1", v0, 1);
        cyc(2'b11, 0, 0);
        cyc(2'b00, 1, 0);
        chk("b2b_nobubble", v0, 1);
        chk("b2b_len", l0, 1);
        chk("b2b_no_ovf", o0, 0);
        cyc(2'b11, 1, 0);
        cyc(2'b00, 1, 0);
        chk("b2b_v3", v0, 1);
        cyc(2'b00, 1, 0);
        chk("b2b_accepts", acc0 - acc_base, 3);

        // mid-run async reset with a pending report and ovf set
        cyc(2'b11, 0, 0);
        cyc(2'b00, 0, 0);
        cyc(2'b11, 0, 0);
        cyc(2'b00, 0, 0);
        chk("pre_rst_ovf", o0, 1);
        repeat (4) cyc(2'b11, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", v0, 0);
        chk("async_len", l0, 0);
        chk("async_sat", s1, 0);
        chk("async_ovf", o0, 0);
        @(negedge clk);
        @(negedge clk);
        in_data = 2'b00;
        rst_n = 1'b1;
        repeat (3) cyc(2'b00, 1, 0);
        chk("post_rst_none", v0, 0);
        chk("post_rst_none_w3", v1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
